// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin N-master arbiter that routes the owner's slave and skips busy slaves.
// Optional tenure limit enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int SIDX_W      = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_request,
    input  logic [NUM_MASTERS*SIDX_W-1:0] m_slave_select,
    input  logic [NUM_SLAVES-1:0]         s_busy,
    output logic [NUM_MASTERS-1:0]        m_grant,
    output logic                          busy,
    output logic [MIDX_W-1:0]             bus_grant,
    output logic [SIDX_W-1:0]             slave_grant,
    output logic                          timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int SN = 2 ** SIDX_W;

    state_t                  state_q, state_d;
    logic [MIDX_W-1:0]       owner_q, owner_d, last_q, last_d, win;
    logic [SIDX_W-1:0]       slv_q, slv_d;
    logic [SN-1:0]           sbusy;
    logic [NUM_MASTERS-1:0]  elig;
    logic                    found, expire;

    // Selects beyond the last real slave look permanently busy.
    assign sbusy = SN'(s_busy) | ~SN'({NUM_SLAVES{1'b1}});

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_elig
        assign elig[i] = m_request[i] & ~sbusy[m_slave_select[i*SIDX_W +: SIDX_W]];
    end

    function automatic logic [MIDX_W-1:0] nth(input logic [MIDX_W-1:0] base, input int k);
        return MIDX_W'((int'(base) + k) % NUM_MASTERS);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!found && elig[nth(last_q, k)]) begin
                found = 1'b1;
                win   = nth(last_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        slv_d   = slv_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = GRANT;
                owner_d = win;
                slv_d   = m_slave_select[int'(win)*SIDX_W +: SIDX_W];
                last_d  = win;
            end
        end else if (!m_request[owner_q] || expire) begin
            state_d = IDLE;
            owner_d = '0;
            slv_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            slv_q   <= '0;
            last_q  <= MIDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            slv_q   <= slv_d;
            last_q  <= last_d;
        end
    end

    assign busy        = state_q == GRANT;
    assign m_grant     = NUM_MASTERS'(busy) << owner_q;
    assign bus_grant   = owner_q;
    assign slave_grant = slv_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // Counter is zero throughout IDLE, so it starts from 0 on every grant.
    assign expire = cnt_q == CW'(TIMEOUT - 1);
    assign cnt_d  = busy ? cnt_q + 1'b1 : '0;
    assign tmo_d  = busy && m_request[owner_q] && expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0 && TIMEOUT > 0;
`endif
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed and randomized checks of bus_arbiter_rr against a cycle reference model.
// Honours ARB_TIMEOUT_EN to match the DUT build.
module tb_bus_arbiter_rr;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 16;

    logic        clk = 1'b0, reset = 1'b1;
    logic [3:0]  req = '0, sb = '0;
    logic [11:0] sel = '0;
    logic [3:0]  m_grant;
    logic        busy, timeout;
    logic [1:0]  bus_grant;
    logic [2:0]  slave_grant;

    int checks = 0, failures = 0;
    int m_own, m_last, m_held, m_slv;
    bit m_tmo;

    bus_arbiter_rr #(.NUM_MASTERS(4), .MIDX_W(2), .NUM_SLAVES(4), .SIDX_W(3), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .m_request(req), .m_slave_select(sel), .s_busy(sb),
        .m_grant(m_grant), .busy(busy), .bus_grant(bus_grant), .slave_grant(slave_grant),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int sel_of(int i);
        return int'((sel >> (3 * i)) & 12'd7);
    endfunction

    function automatic bit elig(int i);
        int s = sel_of(i);
        return req[i] && s < 4 && !sb[s];
    endfunction

    task automatic model_rst();
        m_own = -1; m_last = 3; m_held = 0; m_slv = 0; m_tmo = 0;
    endtask

    task automatic model_edge();
        m_tmo = 0;
        if (m_own < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c = (m_last + k) % 4;
                if (m_own < 0 && elig(c)) begin
                    m_own = c; m_last = c; m_held = 1; m_slv = sel_of(c);
                end
            end
        end else if (!req[m_own]) begin
            m_own = -1; m_slv = 0;
        end else if (TMO_EN && m_held == TMO) begin
            m_own = -1; m_slv = 0; m_tmo = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s.%s got=%0h exp=%0h", tag, what, got, exp);
        end
    endtask

    task automatic check(input string tag);
        chk(tag, "m_grant", 32'(m_grant), m_own >= 0 ? 32'(1) << m_own : 32'd0);
        chk(tag, "busy", 32'(busy), 32'(m_own >= 0));
        chk(tag, "bus_grant", 32'(bus_grant), m_own >= 0 ? 32'(m_own) : 32'd0);
        chk(tag, "slave_grant", 32'(slave_grant), 32'(m_slv));
        chk(tag, "timeout", 32'(timeout), 32'(m_tmo));
        chk(tag, "onehot", 32'($onehot0(m_grant)), 32'd1);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_rst();
        check("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int order[$];
        int exp_o[5] = '{0, 1, 2, 3, 0};
        int len, pulses;
        bit started, ended, pb;

        model_rst();
        req = '0; sel = '0; sb = '0;
        do_reset();

        // single master, slave 2, five cycles
        req = 4'b0001; sel[2:0] = 3'd2;
        for (int i = 0; i < 5; i++) begin
            step("single");
            chk("single", "grant_bits", 32'({m_grant, bus_grant, slave_grant, busy}), 32'({4'b0001, 2'd0, 3'd2, 1'b1}));
        end
        req = '0;
        step("single_rel");
        chk("single_rel", "busy0", 32'(busy), 32'd0);
        step("single_idle");

        // round robin with 3-cycle tenures
        sel = '0; do_reset();
        req = 4'hf; pb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step("rr");
            if (busy && !pb) order.push_back(int'(bus_grant));
            pb = busy;
            req = 4'hf;
            if (m_own >= 0 && m_held == 3) req[m_own] = 1'b0;
        end
        chk("rr", "count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) chk("rr", "order", 32'(order[i]), 32'(exp_o[i]));

        // busy slave skipped, served once free
        req = '0; do_reset();
        sel[2:0] = 3'd1; sel[5:3] = 3'd3; sb = 4'b0010; req = 4'b0011;
        step("skip");
        chk("skip", "bus_grant", 32'(bus_grant), 32'd1);
        chk("skip", "slave_grant", 32'(slave_grant), 32'd3);
        step("skip_hold");
        req = 4'b0001;
        step("skip_rel");
        step("skip_wait");
        chk("skip_wait", "busy0", 32'(busy), 32'd0);
        sb = '0;
        step("skip_free");
        chk("skip_free", "m_grant", 32'(m_grant), 32'b0001);

        // asynchronous reset mid-tenure
        req = '0; sel = '0; do_reset();
        req = 4'b0100;
        step("ar_grant");
        step("ar_hold");
        #2 reset = 1'b1;
        #1;
        model_rst();
        check("ar_async");
        chk("ar_async", "all0", 32'({m_grant, busy, bus_grant, slave_grant}), 32'd0);
        req = 4'hf;
        @(negedge clk) reset = 1'b0;
        step("ar_first");
        chk("ar_first", "m_grant", 32'(m_grant), 32'b0001);

        // out-of-range slave select never granted
        req = '0; do_reset();
        sel[8:6] = 3'd5; req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step("oor");
            chk("oor", "busy0", 32'(busy), 32'd0);
        end

        // tenure limit
        req = '0; sel = '0; do_reset();
        req = 4'b0011; len = 0; pulses = 0; started = 0; ended = 0;
        for (int i = 0; i < 40; i++) begin
            step("tmo");
            if (busy && bus_grant == 2'd0 && !ended) begin started = 1; len++; end
            else if (started) ended = 1;
            pulses += int'(timeout);
        end
        chk("tmo", "tenure", 32'(len), TMO_EN ? 32'd16 : 32'd40);
        chk("tmo", "pulses", 32'(pulses), TMO_EN ? 32'd2 : 32'd0);

        // randomized traffic
        req = '0; do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 4; m++) if ($urandom_range(0, 3) == 0) req[m] = ~req[m];
            if ($urandom_range(0, 3) == 0) sel = 12'($urandom);
            if ($urandom_range(0, 2) == 0) sb = 4'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised N-master, M-slave bus arbiter for the system bus; successor to the two-master fixed arbiter. Grants bus ownership to one master at a time with round-robin fairness, routes the winner's slave selection to the interconnect, and skips masters whose target slave is busy. Sits between the master ports and the address/data mux and slave decoder, which consume `bus_grant` and `slave_grant`.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters (2..16).
- `MIDX_W`, 2: width of the master index; must equal clog2(`NUM_MASTERS`).
- `NUM_SLAVES`, 4: number of slaves (1..2^`SIDX_W`).
- `SIDX_W`, 2: width of the slave index.
- `TIMEOUT`, 16: maximum tenure in cycles (≥2); used only with `ARB_TIMEOUT_EN`.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m_request`  in  NUM_MASTERS  bit i high: master i requests the bus, held for the whole transaction.
- `m_slave_select`  in  NUM_MASTERS*SIDX_W  master i's target slave at `[i*SIDX_W +: SIDX_W]`.
- `s_busy`  in  NUM_SLAVES  bit j high: slave j cannot accept a new transaction.
- `m_grant`  out  NUM_MASTERS  one-hot grant to the current owner; all zero when idle.
- `busy`  out  1  high while any master owns the bus.
- `bus_grant`  out  MIDX_W  index of the current owner; 0 when idle.
- `slave_grant`  out  SIDX_W  slave index latched from the owner at grant; 0 when idle.
- `timeout`  out  1  one-cycle pulse when a tenure is forcibly ended.

## Operation
- Two states: IDLE and GRANT. All outputs are registered.
- Eligible master i: `m_request[i]`=1, its select < `NUM_SLAVES`, and `s_busy[select]`=0.
- IDLE, any eligible master:
  - Pick the first eligible master searching `last_owner+1`, `last_owner+2`, … modulo `NUM_MASTERS`.
  - Go to GRANT.
  - Set `m_grant`, `bus_grant` and `busy`=1.
  - Latch the winner's select into `slave_grant`.
  - Set `last_owner` to the winner.
  - Clear the tenure counter.
- IDLE, no eligible master: remain IDLE with all outputs 0.
- GRANT:
  - Owner request high: hold all outputs.
  - Owner request low: go to IDLE and clear `m_grant`, `bus_grant`, `slave_grant` and `busy`.
- Changes to `m_slave_select` or `s_busy` during GRANT are ignored. The slave is fixed at grant.
- Requests from non-owners during GRANT are ignored until the next arbitration. No preemption occurs except by timeout.
- A master whose request drops before it is granted loses nothing; the pointer does not move.
- The round-robin pointer `last_owner` resets to `NUM_MASTERS-1`, so master 0 wins first after reset.

## Timing
- Grant latency: request sampled at edge k in IDLE → `m_grant` valid after edge k, i.e. 1 cycle.
- Release: owner request low at edge k → outputs cleared after edge k. The earliest next grant follows edge k+1.
- This guarantees at least one idle turnaround cycle between owners: `busy`=0 for ≥1 cycle.
- Reset, asserted asynchronously at any time including mid-GRANT:
  - All outputs go to 0 immediately.
  - State returns to IDLE, `last_owner`=`NUM_MASTERS-1`, tenure counter 0.
- First arbitration occurs at the first rising edge after `reset` deasserts.
- `m_grant` is never multi-hot. `bus_grant` and `slave_grant` are 0 whenever `busy`=0.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- Defined:
  - The tenure counter increments each GRANT cycle.
  - If the owner still requests at the edge where the counter equals `TIMEOUT-1`, force the transition to IDLE. Outputs clear as on a normal release.
  - `timeout`=1 for exactly that following cycle.
  - `last_owner` is already the evicted master, so it is served last in the next round.
  - An owner holds the bus for at most `TIMEOUT` consecutive cycles.
- Not defined:
  - No counter is present.
  - Tenure is unlimited.
  - `timeout` is tied to 0. The port remains.

## Test plan
Defaults: `NUM_MASTERS`=4, `NUM_SLAVES`=4, `TIMEOUT`=16.
- Reset, then `m_request`=4'b0001 with select 2 held 5 cycles → `m_grant`=0001, `bus_grant`=0, `slave_grant`=2, `busy`=1 one cycle after the request, for 5 cycles. All outputs return to 0 one cycle after the request drops.
- All four request continuously; each drops its request after 3 granted cycles and re-raises it the next cycle → grant order 0,1,2,3,0. One `busy`=0 cycle between owners. Never multi-hot.
- `m_request`=4'b0011, master 0 selects slave 1 with `s_busy`=4'b0010, master 1 selects slave 3 → master 1 granted, `slave_grant`=3. Master 0 is granted at the first arbitration after `s_busy[1]` drops.
- Master 2 granted; assert `reset` mid-tenure → all outputs 0 without waiting for a clock edge. After release, with all masters requesting, master 0 wins.
- Master 2 selects slave 5 (≥`NUM_SLAVES`, `SIDX_W`=3 build) → never granted, `busy` stays 0.
- With `ARB_TIMEOUT_EN`: master 0 holds its request 40 cycles and master 1 requests → master 0 owns for 16 cycles, `timeout` pulses 1 cycle, master 1 is granted on the next edge. Without the macro: master 0 owns for all 40 cycles and `timeout` stays 0.
